// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_unit_cond_negate.sv
// Conditional two's-complement negation: y = neg ? -x : x.
module cond_negate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? (~x + WIDTH'(1)) : x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide with HI/LO result registers.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned W2 = 2 * WIDTH;

  state_t state, state_n;
  logic   load, step, commit;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic             sign_a, sign_b, op_r, dz_r;
  logic [W2-1:0]    acc;
  logic [CNT_W-1:0] cnt;

  logic             in_sign_a, in_sign_b;
  logic [WIDTH-1:0] srca_mag, srcb_mag;

  assign in_sign_a = is_signed & srca[WIDTH-1];
  assign in_sign_b = is_signed & srcb[WIDTH-1];

  cond_negate #(.WIDTH(WIDTH)) u_mag_a (.x(srca), .neg(in_sign_a), .y(srca_mag));
  cond_negate #(.WIDTH(WIDTH)) u_mag_b (.x(srcb), .neg(in_sign_b), .y(srcb_mag));

  // One iteration: shift-add for multiply, trial subtract for divide
  logic [WIDTH:0]  mul_sum, rem_sh, div_diff;
  logic [W2-1:0]   acc_step;

  assign mul_sum  = {1'b0, acc[W2-1:WIDTH]} + {1'b0, (acc[0] ? a_mag : '0)};
  assign rem_sh   = acc[W2-1:WIDTH-1];
  assign div_diff = rem_sh - {1'b0, b_mag};

  always_comb begin
    acc_step = acc;
    if (op_r == OP_MUL)
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    else if (div_diff[WIDTH])
      acc_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // Sign correction; a zero-divisor remainder equals |srca| so this restores srca
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  cond_negate #(.WIDTH(W2))    u_fix_p (.x(acc), .neg(sign_a ^ sign_b), .y(prod_fix));
  cond_negate #(.WIDTH(WIDTH)) u_fix_q (.x(acc[WIDTH-1:0]), .neg(sign_a ^ sign_b), .y(quo_fix));
  cond_negate #(.WIDTH(WIDTH)) u_fix_r (.x(acc[W2-1:WIDTH]), .neg(sign_a), .y(rem_fix));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !cancel) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (cancel) begin
          state_n = IDLE;
        end else begin
          step = 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state_n = FIX;
        end
      end
      FIX: begin
        commit  = !cancel;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_mag  <= '0;
      b_mag  <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      op_r   <= 1'b0;
      dz_r   <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load) begin
      a_mag  <= srca_mag;
      b_mag  <= srcb_mag;
      sign_a <= in_sign_a;
      sign_b <= in_sign_b;
      op_r   <= op;
      dz_r   <= (srcb == '0);
      acc    <= (op == OP_MUL) ? {{WIDTH{1'b0}}, srcb_mag} : {{WIDTH{1'b0}}, srca_mag};
      cnt    <= '0;
    end else if (step) begin
      acc <= acc_step;
      cnt <= cnt + CNT_W'(1);
    end
  end

  // HI/LO: direct writes only while idle, otherwise the committed result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
      busy <= 1'b0;
    end else begin
      done <= commit;
      busy <= (state_n != IDLE);
      if (state == IDLE) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end else if (commit) begin
        if (op_r == OP_MUL) begin
          hi <= prod_fix[W2-1:WIDTH];
          lo <= prod_fix[WIDTH-1:0];
        end else begin
          hi <= rem_fix;
          lo <= dz_r ? '1 : quo_fix;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start, op, is_signed, cancel, hi_we, lo_we;
  logic [WIDTH-1:0] srca, srcb, wdata;
  logic             busy, done;
  logic [WIDTH-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];

  muldiv_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .is_signed(is_signed),
    .srca(srca), .srcb(srcb), .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: returns {hi, lo}
  function automatic logic [63:0] model(input logic o, input logic s,
                                        input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [31:0] q, r;
    sa = s ? longint'($signed(a)) : longint'({32'b0, a});
    sb = s ? longint'($signed(b)) : longint'({32'b0, b});
    if (!o) return 64'(sa * sb);
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    q = 32'(sa / sb);
    r = 32'(sa % sb);
    return {r, q};
  endfunction

  // disturb: 0 none, 1 new start at iteration 10, 2 hi/lo write at iteration 10
  task automatic do_op(input string tag, input logic o, input logic s,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int disturb);
    int n;
    logic [63:0] e;
    sb_q.push_back(exp);
    @(negedge clk);
    start = 1'b1; op = o; is_signed = s; srca = a; srcb = b;
    @(posedge clk); #1;
    start = 1'b0; srca = $urandom; srcb = $urandom; is_signed = ~s; op = ~o;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (disturb == 1 && n == 10) begin
        start = 1'b1; srca = 32'h0000_1234; srcb = 32'h0000_0003;
      end else if (disturb == 2 && n == 10) begin
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
      end else begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check_val({tag, "_latency"}, 64'(n), 64'(WIDTH + 1));
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hX;
    check_val({tag, "_hilo"}, {hi, lo}, e);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    check_val({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    logic [31:0] ra, rb;
    logic ro, rs;
    reset = 1'b1; start = 1'b0; op = 1'b0; is_signed = 1'b0; cancel = 1'b0;
    hi_we = 1'b0; lo_we = 1'b0; srca = '0; srcb = '0; wdata = '0;
    #12;
    check_val("reset_outs", {28'd0, busy, done, 2'b00, hi}, 64'd0);
    check_val("reset_lo", 64'(lo), 64'd0);
    @(negedge clk); reset = 1'b0;

    do_op("mul_u_max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
    do_op("mul_s_m3x7", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 0);
    do_op("mul_u_m3x7", 1'b0, 1'b0, 32'hFFFF_FFFD, 32'd7, 64'h0000_0006_FFFF_FFEB, 0);
    do_op("div_s_m7d2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    do_op("div_u_100d7", 1'b1, 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 0);
    do_op("div_u_5d0", 1'b1, 1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 0);
    do_op("div_s_m5d0", 1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 0);
    do_op("div_s_ovf", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 0);
    do_op("start_busy", 1'b0, 1'b0, 32'd1000, 32'd3000, 64'd3000000, 1);
    do_op("we_busy", 1'b1, 1'b0, 32'd1000, 32'd7, {32'd6, 32'd142}, 2);

    // Direct HI/LO writes while idle
    @(negedge clk); hi_we = 1'b1; wdata = 32'h1111_2222;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h3333_4444;
    @(negedge clk); lo_we = 1'b0;
    check_val("mthi_mtlo", {hi, lo}, 64'h1111_2222_3333_4444);

    // start with cancel in the same cycle is dropped
    start = 1'b1; cancel = 1'b1; op = 1'b0; srca = 32'd9; srcb = 32'd9;
    @(negedge clk); start = 1'b0; cancel = 1'b0;
    check_val("start_cancel", 64'(busy), 64'd0);

    // Cancel at iteration 10
    start = 1'b1; op = 1'b0; is_signed = 1'b0; srca = 32'd5; srcb = 32'd5;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
    check_val("cancel_busy_before", 64'(busy), 64'd1);
    cancel = 1'b1;
    @(posedge clk); #1; cancel = 1'b0;
    check_val("cancel_busy", 64'(busy), 64'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (done) n++; end
    check_val("cancel_no_done", 64'(n), 64'd0);
    check_val("cancel_hilo", {hi, lo}, 64'h1111_2222_3333_4444);

    // Random operations against the model
    for (int i = 0; i < 8; i++) begin
      ra = $urandom; rb = (i == 3) ? 32'd0 : $urandom_range(0, 7) == 0 ? $urandom_range(1, 9) : $urandom;
      ro = 1'(i % 2); rs = 1'(i / 2 % 2);
      do_op("rand", ro, rs, ra, rb, model(ro, rs, ra, rb), 0);
    end

    // Async reset mid-run
    @(negedge clk);
    start = 1'b1; op = 1'b0; is_signed = 1'b0; srca = 32'd77; srcb = 32'd77;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    #2; reset = 1'b1; #1;
    check_val("rst_mid_ctl", {62'd0, busy, done}, 64'd0);
    check_val("rst_mid_hilo", {hi, lo}, 64'd0);
    @(negedge clk); reset = 1'b0;
    do_op("after_rst", 1'b0, 1'b1, 32'd6, 32'd7, 64'd42, 0);

    check_val("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit for the execute stage; next generation of the pipeline's fixed 32-bit multiplier.
- Adds division, signed/unsigned mode, a busy/done handshake for the hazard detector, a cancel input for flushes, and direct HI/LO writes.
- Results are held in internal HI/LO registers that the execute-stage output mux reads.

Parameters:
- WIDTH, 32, operand width in bits; must be even and at least 4.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  launch an operation; sampled only in IDLE.
- op  in  1  0 = multiply, 1 = divide.
- is_signed  in  1  1 = two's-complement operands.
- srca  in  WIDTH  multiplicand or dividend.
- srcb  in  WIDTH  multiplier or divisor.
- cancel  in  1  abort the operation in flight (pipeline flush).
- hi_we  in  1  write wdata into HI (mthi); honoured only in IDLE.
- lo_we  in  1  write wdata into LO (mtlo); honoured only in IDLE.
- wdata  in  WIDTH  data for hi_we/lo_we.
- busy  out  1  state != IDLE; the hazard unit stalls on it.
- done  out  1  one-cycle registered pulse when HI/LO take a new result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, active-high): state=IDLE; hi, lo, done, counter and datapath registers all 0.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - start & ~cancel: capture |srca|, |srcb| (magnitudes when is_signed, else raw), the operand signs, op and zero-divisor flag; counter=0; go to RUN.
  - start & cancel in the same cycle: cancel wins; stay in IDLE.
  - hi_we/lo_we: write wdata on the edge. If start is also asserted, the write happens and the operation starts.
- RUN: one iteration per edge.
  - Multiply: radix-2 shift-add over a 2*WIDTH accumulator.
  - Divide: restoring division, one quotient bit per edge.
  - After WIDTH iterations (counter == WIDTH-1), go to FIX.
- FIX, one edge:
  - Apply sign correction. Product is negated iff the operand signs differ. Quotient is negated iff the signs differ. Remainder takes the dividend's sign.
  - Write HI/LO, set done=1 for one cycle, go to IDLE.
- Latency: the start edge is edge 0; HI/LO update and done rises on edge WIDTH+1 (33 for WIDTH=32). busy is high from edge 0 until edge WIDTH+1.
- Result mapping:
  - Multiply: {hi,lo} = full 2*WIDTH product.
  - Divide: lo = quotient (truncated toward zero); hi = remainder.
- Divide by zero, either mode: lo = all ones; hi = srca unmodified; sign fix is bypassed. Full latency still applies.
- Signed overflow (most-negative / -1): lo = most-negative, hi = 0, produced naturally by the algorithm.
- Ignored inputs while busy: start, op, is_signed, srca, srcb, hi_we and lo_we. Writes are not queued.
- cancel in RUN or FIX: go to IDLE on that edge; HI/LO are unchanged; no done pulse.
- Reset asserted mid-operation: immediate return to IDLE with outputs cleared.
- done is low on every cycle other than the pulse.

Decomposition:
- Shared package muldiv_pkg holds:
  - OP_MUL=1'b0 and OP_DIV=1'b1;
  - state encoding IDLE=2'd0, RUN=2'd1, FIX=2'd2;
  - the default WIDTH.
- One sub-module: cond_negate (WIDTH-parametrised; outputs -x when neg=1, else x). It is used for operand magnitudes and for result correction.

Test Plan:
- Unsigned multiply 0xFFFFFFFF*0xFFFFFFFF, start at edge 0 -> done on edge 33, hi=0xFFFFFFFE, lo=0x00000001, busy low afterwards.
- Signed multiply -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; the same operands unsigned -> hi=0x00000006, lo=0xFFFFFFEB.
- Signed divide -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; unsigned 100/7 -> lo=14, hi=2.
- Divide by zero and overflow:
  - unsigned 5/0 -> lo=0xFFFFFFFF, hi=5;
  - signed 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Handshakes:
  - start with new operands at iteration 10 -> ignored, first result unchanged;
  - cancel at iteration 10 -> busy low next cycle, HI/LO keep prior values, no done;
  - hi_we while busy -> no effect.
- Reset asserted mid-RUN without a clock edge -> busy, done, hi and lo read 0 immediately; after release, a fresh 6*7 gives lo=42.
